// File: rtl/sel_pkg.sv
// Shared types and sizing for the selector distributor.
// One input stream fanned out to N single-entry lanes.
package sel_pkg;
  localparam int W      = 2;
  localparam int N      = 4;
  localparam int SW     = $clog2(N);
  localparam int DROP_W = 8;

  typedef logic [W-1:0]  sym_t;
  typedef logic [SW-1:0] lane_idx_t;
endpackage

// File: rtl/sel_dist_lane.sv
// One-entry holding register for a single output lane.
// A load in the same cycle as a drain keeps the lane full.
module sel_dist_lane
  import sel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  sym_t data,
  input  logic ready,
  output logic valid,
  output sym_t q,
  output logic can_load
);

  assign can_load = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sel_distributor.sv
// Routes one input symbol stream to one of N lanes,
// addressed by in_sel or by a round-robin pointer.
module sel_distributor
  import sel_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [W-1:0]        in_data,
  input  logic [SW-1:0]       in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N*W-1:0]      out_data,
  output logic [N-1:0]        out_valid,
  input  logic [N-1:0]        out_ready,
  output logic [SW-1:0]       rr_ptr,
  output logic [DROP_W-1:0]   drop_cnt
);

  lane_idx_t      tgt;
  logic [N-1:0]   can_load;
  logic [N-1:0]   load;
  logic           accept;

  assign tgt      = mode ? rr_ptr : in_sel;
  assign in_ready = can_load[tgt];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign load[i] = accept && (tgt == lane_idx_t'(i));

    sel_dist_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .data     (in_data),
      .ready    (out_ready[i]),
      .valid    (out_valid[i]),
      .q        (out_data[i*W +: W]),
      .can_load (can_load[i])
    );
  end

  // N is a power of two, so the pointer wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && mode) begin
      rr_ptr <= rr_ptr + lane_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule
